// File: rtl/adc_ram_half_reader.sv
// adc_ram_half_reader: averages each completed half of the ping-pong ADC DPBRAM
//   i_clk, i_rst (async, active-low)      clock and reset
//   i_en, i_wr_addr, i_wr_cs              writer snoop; half-complete event capture
//   o_rd_addr, o_rd_en                    port-B read of the completed half (V and C RAM)
//   i_v_rd_data, i_c_rd_data              port-B read data, RAM_LATENCY clocks after o_rd_en
//   o_v_avg, o_c_avg, o_half, o_avg_valid one averaged pair per half, single-cycle strobe
//   i_overrun_clr, o_overrun              sticky flag: event accepted while busy
//   o_busy, o_debug_state                 FSM visibility
module adc_ram_half_reader #(
  parameter int RAM_DEPTH   = 2048,
  parameter int DATA_WIDTH  = 24,
  parameter int RAM_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [14:0]           i_wr_addr,
  input  logic                  i_wr_cs,
  output logic [14:0]           o_rd_addr,
  output logic                  o_rd_en,
  input  logic [DATA_WIDTH-1:0] i_v_rd_data,
  input  logic [DATA_WIDTH-1:0] i_c_rd_data,
  output logic [DATA_WIDTH-1:0] o_v_avg,
  output logic [DATA_WIDTH-1:0] o_c_avg,
  output logic                  o_avg_valid,
  output logic                  o_half,
  input  logic                  i_overrun_clr,
  output logic                  o_overrun,
  output logic                  o_busy,
  output logic [1:0]            o_debug_state
);
  localparam int N    = RAM_DEPTH / 2;
  localparam int LOGN = $clog2(N);
  localparam int ACCW = DATA_WIDTH + LOGN;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic pend, pend_half, half;
  logic ev, ev_half, go, go_half, start;
  logic [LOGN-1:0] cnt;
  logic [RAM_LATENCY-1:0] dly;
  logic [ACCW-1:0] v_acc, c_acc;
  // An event seen in IDLE starts the readout at the same edge it is captured,
  // so READ begins in the very next cycle; otherwise it waits in pend.
  always_comb begin
    ev_half = i_wr_addr == 15'(RAM_DEPTH - 1);
    ev      = i_en && i_wr_cs && (ev_half || i_wr_addr == 15'(N - 1));
    go      = ev || pend;
    go_half = ev ? ev_half : pend_half;
    start   = state == IDLE && go;
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE  ? (go ? READ : IDLE) :
              state == READ  ? (cnt == LOGN'(N - 1) ? DRAIN : READ) :
              state == DRAIN ? (cnt == LOGN'(RAM_LATENCY - 1) ? DONE : DRAIN) :
                               IDLE;
  end
  always_comb begin
    o_rd_en       = state == READ;
    o_busy        = state != IDLE;
    o_debug_state = state;
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      pend        <= 1'b0;
      pend_half   <= 1'b0;
      half        <= 1'b0;
      cnt         <= '0;
      o_rd_addr   <= '0;
      dly         <= '0;
      v_acc       <= '0;
      c_acc       <= '0;
      o_v_avg     <= '0;
      o_c_avg     <= '0;
      o_half      <= 1'b0;
      o_avg_valid <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (start) pend <= 1'b0;
      else if (ev) {pend, pend_half} <= {1'b1, ev_half};
      if (ev && state != IDLE) o_overrun <= 1'b1;
      else if (i_overrun_clr) o_overrun <= 1'b0;
      cnt <= (state != state_n || state == IDLE) ? '0 : cnt + 1'b1;
      if (start) begin
        half      <= go_half;
        o_rd_addr <= go_half ? 15'(N) : 15'd0;
      end else if (state == READ && cnt != LOGN'(N - 1)) o_rd_addr <= o_rd_addr + 15'd1;
      // dly[RAM_LATENCY-1] marks the cycle whose closing edge samples a requested word
      dly[0] <= o_rd_en;
      for (int i = 1; i < RAM_LATENCY; i++) dly[i] <= dly[i-1];
      if (start) begin
        v_acc <= '0;
        c_acc <= '0;
      end else if (dly[RAM_LATENCY-1]) begin
        v_acc <= v_acc + {{LOGN{i_v_rd_data[DATA_WIDTH-1]}}, i_v_rd_data};
        c_acc <= c_acc + {{LOGN{i_c_rd_data[DATA_WIDTH-1]}}, i_c_rd_data};
      end
      o_avg_valid <= state == DONE;
      // dropping the low LOGN bits is the arithmetic shift (floor division by N)
      if (state == DONE) begin
        o_v_avg <= v_acc[ACCW-1:LOGN];
        o_c_avg <= c_acc[ACCW-1:LOGN];
        o_half  <= half;
      end
    end
endmodule

// File: tb/tb_adc_ram_half_reader.sv
// tb_adc_ram_half_reader: self-checking bench for adc_ram_half_reader (N=4, latency 2)
module tb_adc_ram_half_reader;
  logic clk = 0, i_rst = 0, i_en = 1, i_wr_cs = 0, i_overrun_clr = 0;
  logic [14:0] i_wr_addr = 0, o_rd_addr;
  logic o_rd_en, o_avg_valid, o_half, o_overrun, o_busy;
  logic [23:0] v_rd, c_rd, o_v_avg, o_c_avg;
  logic [1:0] o_debug_state;
  int tests = 0, fails = 0;
  int vmem[8] = '{10, 20, 30, 40, -8, -8, -8, -9};
  int cmem[8] = '{1, 1, 1, 1, 100, 0, 0, 0};
  logic [23:0] v1, v2, c1, c2;
  bit en_l[32], val_l[32], busy_l[32], ovr_l[32], half_l[32], z_l[32];
  int addr_l[32], v_l[32], c_l[32];

  adc_ram_half_reader #(.RAM_DEPTH(8), .DATA_WIDTH(24), .RAM_LATENCY(2)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_wr_addr(i_wr_addr), .i_wr_cs(i_wr_cs),
    .o_rd_addr(o_rd_addr), .o_rd_en(o_rd_en), .i_v_rd_data(v_rd), .i_c_rd_data(c_rd),
    .o_v_avg(o_v_avg), .o_c_avg(o_c_avg), .o_avg_valid(o_avg_valid), .o_half(o_half),
    .i_overrun_clr(i_overrun_clr), .o_overrun(o_overrun), .o_busy(o_busy),
    .o_debug_state(o_debug_state));

  always #5 clk = ~clk;

  // two-stage registered read port: address in cycle k, data sampled at end of k+2
  always @(posedge clk) begin
    v1 <= 24'(vmem[o_rd_addr[2:0]]);
    c1 <= 24'(cmem[o_rd_addr[2:0]]);
    v2 <= v1;
    c2 <= c1;
  end
  assign v_rd = v2;
  assign c_rd = c2;

  function automatic int favg(input bit ch, input int h);
    int s = 0;
    for (int k = 0; k < 4; k++) s += ch ? cmem[h*4+k] : vmem[h*4+k];
    return (s - (((s % 4) + 4) % 4)) / 4;
  endfunction

  function automatic bit in_read(input int c, input int s);
    return c >= s && c < s + 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // writer fills one half; the last write (top address) lands on edge 0
  task automatic fire(input int h);
    for (int k = 0; k < 4; k++) begin
      i_wr_cs = 1;
      i_wr_addr = 15'(h * 4 + k);
      tick();
    end
    i_wr_cs = 0;
  endtask

  task automatic watch(input int n, input int ev_c, input int ev_h, input int clr_c,
                       input int en_off_c, input int rst_c, input int rst_rel_c);
    for (int c = 1; c <= n; c++) begin
      i_wr_cs = (c == ev_c);
      i_wr_addr = ev_h ? 15'd7 : 15'd3;
      i_overrun_clr = (c == clr_c);
      if (c == en_off_c) i_en = 0;
      if (c == rst_c) i_rst = 0;
      if (c == rst_rel_c) i_rst = 1;
      #1;
      en_l[c] = o_rd_en; addr_l[c] = int'(o_rd_addr); val_l[c] = o_avg_valid;
      busy_l[c] = o_busy; ovr_l[c] = o_overrun; half_l[c] = o_half;
      v_l[c] = $signed(o_v_avg); c_l[c] = $signed(o_c_avg);
      z_l[c] = {o_rd_addr, o_rd_en, o_v_avg, o_c_avg, o_avg_valid, o_half, o_overrun,
                o_busy, o_debug_state} == '0;
      @(posedge clk);
      #1;
    end
    i_wr_cs = 0;
    i_overrun_clr = 0;
  endtask

  task automatic test_reset();
    i_rst = 0;
    repeat (3) tick();
    tests++;
    if (o_rd_addr !== 0 || o_rd_en !== 0 || o_avg_valid !== 0 || o_overrun !== 0 ||
        o_busy !== 0 || o_debug_state !== 0 || o_v_avg !== 0 || o_c_avg !== 0 || o_half !== 0) begin
      fails++;
      $display("FAIL reset_outputs: addr=%0d en=%b valid=%b ovr=%b busy=%b st=%0d, required all 0",
               o_rd_addr, o_rd_en, o_avg_valid, o_overrun, o_busy, o_debug_state);
    end
    i_rst = 1;
    tick();
    tests++;
    if (o_busy !== 0) begin fails++; $display("FAIL reset_idle: busy=%b required 0", o_busy); end
  endtask

  task automatic test_readout(input int h);
    fire(h);
    watch(12, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      tests++;
      if (en_l[c] !== in_read(c, 1)) begin
        fails++; $display("FAIL rd_en h%0d c%0d: got %b required %b", h, c, en_l[c], in_read(c, 1));
      end
      tests++;
      if (val_l[c] !== (c == 8)) begin
        fails++; $display("FAIL avg_valid h%0d c%0d: got %b required %b", h, c, val_l[c], c == 8);
      end
      if (in_read(c, 1)) begin
        tests++;
        if (addr_l[c] !== h * 4 + c - 1) begin
          fails++; $display("FAIL rd_addr h%0d c%0d: got %0d required %0d", h, c, addr_l[c], h*4+c-1);
        end
      end
    end
    tests++;
    if (v_l[8] !== favg(0, h) || c_l[8] !== favg(1, h) || half_l[8] !== h[0]) begin
      fails++;
      $display("FAIL avg h%0d: v=%0d c=%0d half=%b required v=%0d c=%0d half=%0d",
               h, v_l[8], c_l[8], half_l[8], favg(0, h), favg(1, h), h);
    end
    tests++;
    if (addr_l[10] !== h * 4 + 3) begin
      fails++; $display("FAIL addr_hold h%0d: got %0d required %0d", h, addr_l[10], h*4+3);
    end
  endtask

  task automatic test_spec_values();
    tests++;
    if (favg(0, 0) != 25 || favg(1, 0) != 1 || favg(0, 1) != -9 || favg(1, 1) != 25) begin
      fails++; $display("FAIL model_values: %0d %0d %0d %0d required 25 1 -9 25",
                        favg(0, 0), favg(1, 0), favg(0, 1), favg(1, 1));
    end
    test_readout(0);
    test_readout(1);
  endtask

  task automatic test_overrun();
    fire(0);
    watch(20, 3, 1, 0, 0, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      tests++;
      if (ovr_l[c] !== (c >= 4)) begin
        fails++; $display("FAIL overrun_set c%0d: got %b required %b", c, ovr_l[c], c >= 4);
      end
      tests++;
      if (en_l[c] !== (in_read(c, 1) || in_read(c, 9))) begin
        fails++; $display("FAIL ovr_rd_en c%0d: got %b", c, en_l[c]);
      end
      tests++;
      if (val_l[c] !== (c == 8 || c == 16)) begin
        fails++; $display("FAIL ovr_valid c%0d: got %b", c, val_l[c]);
      end
    end
    tests++;
    if (addr_l[9] !== 4 || addr_l[12] !== 7) begin
      fails++; $display("FAIL ovr_addr: got %0d..%0d required 4..7", addr_l[9], addr_l[12]);
    end
    tests++;
    if (v_l[8] !== favg(0, 0) || c_l[8] !== favg(1, 0) || half_l[8] !== 0) begin
      fails++; $display("FAIL ovr_first: v=%0d c=%0d half=%b", v_l[8], c_l[8], half_l[8]);
    end
    tests++;
    if (v_l[16] !== favg(0, 1) || c_l[16] !== favg(1, 1) || half_l[16] !== 1) begin
      fails++; $display("FAIL ovr_second: v=%0d c=%0d half=%b", v_l[16], c_l[16], half_l[16]);
    end
    fire(0);
    watch(20, 2, 1, 2, 0, 0, 0);
    tests++;
    if (ovr_l[3] !== 1) begin fails++; $display("FAIL set_beats_clr: got %b required 1", ovr_l[3]); end
    watch(3, 0, 0, 1, 0, 0, 0);
    tests++;
    if (ovr_l[1] !== 1 || ovr_l[2] !== 0) begin
      fails++; $display("FAIL overrun_clr: got %b,%b required 1,0", ovr_l[1], ovr_l[2]);
    end
  endtask

  task automatic test_enable();
    i_en = 0;
    fire(0);
    watch(12, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      tests++;
      if (en_l[c] !== 0 || busy_l[c] !== 0 || val_l[c] !== 0) begin
        fails++; $display("FAIL en_gate c%0d: rd_en=%b busy=%b valid=%b required 0", c, en_l[c], busy_l[c], val_l[c]);
      end
    end
    i_en = 1;
    fire(1);
    watch(12, 0, 0, 0, 2, 0, 0);
    tests++;
    if (val_l[8] !== 1 || v_l[8] !== favg(0, 1) || c_l[8] !== favg(1, 1) || half_l[8] !== 1) begin
      fails++; $display("FAIL en_drop: valid=%b v=%0d c=%0d half=%b", val_l[8], v_l[8], c_l[8], half_l[8]);
    end
    tests++;
    if (en_l[4] !== 1 || addr_l[4] !== 7) begin
      fails++; $display("FAIL en_drop_read: rd_en=%b addr=%0d required 1,7", en_l[4], addr_l[4]);
    end
    i_en = 1;
  endtask

  task automatic test_reset_mid();
    fire(0);
    watch(12, 0, 0, 0, 0, 2, 4);
    for (int c = 1; c <= 12; c++) begin
      tests++;
      if (val_l[c] !== 0 || (c >= 2 && en_l[c] !== 0)) begin
        fails++; $display("FAIL rst_mid c%0d: valid=%b rd_en=%b required 0", c, val_l[c], en_l[c]);
      end
    end
    tests++;
    if (z_l[2] !== 1 || z_l[3] !== 1) begin
      fails++; $display("FAIL rst_mid_zero: got %b%b required 11", z_l[2], z_l[3]);
    end
    test_readout(0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 8; k++) begin
        vmem[k] = int'($signed(24'($urandom)));
        cmem[k] = int'($signed(24'($urandom)));
      end
      repeat ($urandom_range(0, 3)) tick();
      test_readout(int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_spec_values();
    test_overrun();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
